// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared lane types and FIFO read-side constants
package serdes_pkg;

    localparam int LOGIC_SIZE      = 8;
    localparam int FIFO_RD_LATENCY = 1;

    typedef logic [LOGIC_SIZE-1:0] beat_t;

endpackage

// File: rtl/axis_fifo_reader_skid_buffer.sv
// rtl/axis_fifo_reader_skid_buffer.sv - circular skid buffer with occupancy count and registered valid
module skid_buffer #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          valid,
    output logic [OW-1:0] occ
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ_next;

    // pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        occ_next = occ;
        if (push && !pop)
            occ_next = occ + OW'(1);
        else if (!push && pop)
            occ_next = occ - OW'(1);
    end

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            assert (!(push && !pop && occ == OW'(DEPTH)) && occ_next <= OW'(DEPTH));
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            occ   <= occ_next;
            valid <= (occ_next != '0);
        end
    end

endmodule

// File: rtl/axis_fifo_reader.sv
// rtl/axis_fifo_reader.sv - drains the async FIFO read port into an AXI-Stream master
// Define AXIS_FIFO_READER_TLAST_EN to frame the stream with o_tlast every PKT_LEN beats.
module axis_fifo_reader
    import serdes_pkg::FIFO_RD_LATENCY;
#(
    parameter int LOGIC_SIZE = serdes_pkg::LOGIC_SIZE,
    parameter int SKID_DEPTH = 2,
    parameter int PKT_LEN    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_rr,
    input  logic                  i_rempty,
    input  logic [LOGIC_SIZE-1:0] i_rdata,
    output logic                  o_tvalid,
    output logic [LOGIC_SIZE-1:0] o_tdata,
    input  logic                  i_tready,
`ifdef AXIS_FIFO_READER_TLAST_EN
    output logic                  o_tlast,
`endif
    output logic [31:0]           o_beats
);
    localparam int OW = $clog2(SKID_DEPTH + 1);

    logic [OW-1:0]              occ;
    logic [FIFO_RD_LATENCY-1:0] rd_pipe;
    logic                       inflight;
    logic                       pop;
    logic                       xfer;
    logic [OW:0]                in_use;

    assign inflight = rd_pipe[FIFO_RD_LATENCY-1];
    assign xfer     = o_tvalid && i_tready;

    // beats held or already requested, less the one leaving this cycle; kept combinational
    // from i_tready so a draining buffer can be refilled every cycle
    assign in_use = {1'b0, occ} + {{OW{1'b0}}, inflight} - {{OW{1'b0}}, xfer};
    assign o_rr   = !i_rempty && (in_use < (OW+1)'(SKID_DEPTH));
    assign pop    = o_rr && !i_rempty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pipe <= '0;
            o_beats <= '0;
        end else begin
            rd_pipe <= FIFO_RD_LATENCY'(pop);
            if (xfer)
                o_beats <= o_beats + 32'd1;
        end
    end

    skid_buffer #(
        .W     (LOGIC_SIZE),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (inflight),
        .push_data (i_rdata),
        .pop       (xfer),
        .head_data (o_tdata),
        .valid     (o_tvalid),
        .occ       (occ)
    );

`ifdef AXIS_FIFO_READER_TLAST_EN
    localparam int CW = $clog2(PKT_LEN + 1);

    logic [CW-1:0] beat_cnt;

    // counter only moves on xfer, so o_tlast is stable for the beat at the head
    assign o_tlast = o_tvalid && (beat_cnt == CW'(PKT_LEN - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            beat_cnt <= '0;
        else if (xfer)
            beat_cnt <= o_tlast ? '0 : beat_cnt + CW'(1);
    end
`else
    logic unused_pkt_len;
    assign unused_pkt_len = (PKT_LEN == 0);
`endif

endmodule
